// File: rtl/dmem_arb_pkg.sv
// Shared types and widths for the data-memory arbiter.
package dmem_arb_pkg;

   localparam int unsigned CNT_W = 4;

   typedef enum logic [1:0] {IDLE, ACCESS, DONE} arb_state_t;
   typedef enum logic       {OWN_CPU, OWN_DMA}    owner_t;

endpackage

// File: rtl/dmem_arbiter_starve_counter.sv
// Saturating counter of consecutive CPU grants made while the DMA port waits.
module starve_counter
   import dmem_arb_pkg::*;
#(
   parameter int unsigned MAX = 4
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic inc_i,
   input  logic clr_i,
   output logic sat_o
);

   localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (inc_i && (cnt_q != MAX_C)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign sat_o = (cnt_q == MAX_C);

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter for the data memory: CPU has priority, DMA is guaranteed
// a grant after STARVE_MAX back-to-back CPU grants while it waits.
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int unsigned DATA_W     = 64,
   parameter int unsigned ADDR_W     = 64,
   parameter int unsigned MEM_LAT    = 1,
   parameter int unsigned STARVE_MAX = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_ack,
   output logic              cpu_stall,
   input  logic              dma_req,
   input  logic              dma_we,
   input  logic [ADDR_W-1:0] dma_addr,
   input  logic [DATA_W-1:0] dma_wdata,
   output logic [DATA_W-1:0] dma_rdata,
   output logic              dma_ack,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_we,
   output logic              mem_re,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam logic [CNT_W-1:0] LAT_C = CNT_W'(MEM_LAT);

   arb_state_t        state_q, state_d;
   owner_t            owner_q, owner_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [CNT_W-1:0]  lat_q, lat_d;
   logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
   logic [DATA_W-1:0] dma_rdata_q, dma_rdata_d;
   logic              starve_inc, starve_clr, starve_sat;

   starve_counter #(
      .MAX (STARVE_MAX)
   ) u_starve (
      .clk_i  (clk),
      .rst_ni (rst),
      .inc_i  (starve_inc),
      .clr_i  (starve_clr),
      .sat_o  (starve_sat)
   );

   always_comb begin
      state_d     = state_q;
      owner_d     = owner_q;
      we_d        = we_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      lat_d       = lat_q;
      cpu_rdata_d = cpu_rdata_q;
      dma_rdata_d = dma_rdata_q;
      starve_inc  = 1'b0;
      starve_clr  = 1'b0;
      mem_addr    = '0;
      mem_wdata   = '0;
      mem_we      = 1'b0;
      mem_re      = 1'b0;
      cpu_ack     = 1'b0;
      dma_ack     = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (dma_req && (!cpu_req || starve_sat)) begin
               owner_d    = OWN_DMA;
               we_d       = dma_we;
               addr_d     = dma_addr;
               wdata_d    = dma_wdata;
               lat_d      = LAT_C;
               state_d    = ACCESS;
               starve_clr = 1'b1;
            end else if (cpu_req) begin
               owner_d    = OWN_CPU;
               we_d       = cpu_we;
               addr_d     = cpu_addr;
               wdata_d    = cpu_wdata;
               lat_d      = LAT_C;
               state_d    = ACCESS;
               starve_inc = dma_req;
               starve_clr = !dma_req;
            end
         end
         ACCESS: begin
            mem_addr  = addr_q;
            mem_wdata = wdata_q;
            mem_re    = !we_q;
            // lat_q still equals MEM_LAT only in the first ACCESS cycle
            mem_we    = we_q && (lat_q == LAT_C);
            lat_d     = lat_q - 1'b1;
            if (lat_q == CNT_W'(1)) begin
               state_d = DONE;
               if (!we_q) begin
                  if (owner_q == OWN_CPU) begin
                     cpu_rdata_d = mem_rdata;
                  end else begin
                     dma_rdata_d = mem_rdata;
                  end
               end
            end
         end
         DONE: begin
            cpu_ack = (owner_q == OWN_CPU);
            dma_ack = (owner_q == OWN_DMA);
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         owner_q     <= OWN_CPU;
         we_q        <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         lat_q       <= '0;
         cpu_rdata_q <= '0;
         dma_rdata_q <= '0;
      end else begin
         state_q     <= state_d;
         owner_q     <= owner_d;
         we_q        <= we_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         lat_q       <= lat_d;
         cpu_rdata_q <= cpu_rdata_d;
         dma_rdata_q <= dma_rdata_d;
      end
   end

   assign cpu_rdata = cpu_rdata_q;
   assign dma_rdata = dma_rdata_q;
   assign cpu_stall = cpu_req & ~cpu_ack;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: d1 runs MEM_LAT=1/STARVE_MAX=2, d3 runs MEM_LAT=3.
module tb_dmem_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        cpu_req = 1'b0, cpu_we = 1'b0, dma_req = 1'b0, dma_we = 1'b0;
   logic [63:0] cpu_addr = '0, cpu_wdata = '0, dma_addr = '0, dma_wdata = '0;

   logic [63:0] d1_cpu_rdata, d1_dma_rdata, d1_mem_addr, d1_mem_wdata, d1_mem_rdata;
   logic        d1_cpu_ack, d1_cpu_stall, d1_dma_ack, d1_mem_we, d1_mem_re;
   logic [63:0] d3_cpu_rdata, d3_dma_rdata, d3_mem_addr, d3_mem_wdata, d3_mem_rdata;
   logic        d3_cpu_ack, d3_cpu_stall, d3_dma_ack, d3_mem_we, d3_mem_re;

   logic [63:0] m1 [0:255];
   logic [63:0] m3 [0:255];
   logic        ld_en = 1'b0;
   logic [7:0]  ld_addr = '0;
   logic [63:0] ld_data = '0;

   int n_chk = 0;
   int n_err = 0;
   int re1 = 0, we1 = 0, re3 = 0, we3 = 0, both = 0;

   always #5 clk = ~clk;

   dmem_arbiter #(.DATA_W(64), .ADDR_W(64), .MEM_LAT(1), .STARVE_MAX(2)) d1 (
      .clk(clk), .rst(rst),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_rdata(d1_cpu_rdata), .cpu_ack(d1_cpu_ack), .cpu_stall(d1_cpu_stall),
      .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
      .dma_rdata(d1_dma_rdata), .dma_ack(d1_dma_ack),
      .mem_addr(d1_mem_addr), .mem_we(d1_mem_we), .mem_re(d1_mem_re),
      .mem_wdata(d1_mem_wdata), .mem_rdata(d1_mem_rdata));

   dmem_arbiter #(.DATA_W(64), .ADDR_W(64), .MEM_LAT(3), .STARVE_MAX(4)) d3 (
      .clk(clk), .rst(rst),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_rdata(d3_cpu_rdata), .cpu_ack(d3_cpu_ack), .cpu_stall(d3_cpu_stall),
      .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
      .dma_rdata(d3_dma_rdata), .dma_ack(d3_dma_ack),
      .mem_addr(d3_mem_addr), .mem_we(d3_mem_we), .mem_re(d3_mem_re),
      .mem_wdata(d3_mem_wdata), .mem_rdata(d3_mem_rdata));

   // Memory models: combinational read, write on the clock edge.
   assign d1_mem_rdata = m1[d1_mem_addr[7:0]];
   assign d3_mem_rdata = m3[d3_mem_addr[7:0]];

   always @(posedge clk) begin
      if (ld_en) begin
         m1[ld_addr] <= ld_data;
         m3[ld_addr] <= ld_data;
      end else begin
         if (d1_mem_we) m1[d1_mem_addr[7:0]] <= d1_mem_wdata;
         if (d3_mem_we) m3[d3_mem_addr[7:0]] <= d3_mem_wdata;
      end
   end

   always @(negedge clk) begin
      if (d1_mem_re) re1++;
      if (d1_mem_we) we1++;
      if (d3_mem_re) re3++;
      if (d3_mem_we) we3++;
      if ((d1_cpu_ack && d1_dma_ack) || (d3_cpu_ack && d3_dma_ack)) both++;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   typedef struct {
      string       name;
      bit          sel;
      bit          dma;
      bit          we;
      logic [63:0] addr;
      logic [63:0] wdata;
      logic [63:0] exp_rd;
      int          exp_lat;
   } vec_t;

   vec_t vecs [9];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic f_ack(input bit sel, input bit dma);
      if (sel) return dma ? d3_dma_ack : d3_cpu_ack;
      return dma ? d1_dma_ack : d1_cpu_ack;
   endfunction

   function automatic logic [63:0] f_rd(input bit sel, input bit dma);
      if (sel) return dma ? d3_dma_rdata : d3_cpu_rdata;
      return dma ? d1_dma_rdata : d1_cpu_rdata;
   endfunction

   task automatic load(input logic [7:0] a, input logic [63:0] d);
      ld_addr = a;
      ld_data = d;
      ld_en   = 1'b1;
      @(posedge clk);
      #1 ld_en = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b0;
      cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
      dma_req = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_wdata = '0;
      #1;
      chk("reset d1 outputs", d1_mem_addr | d1_mem_wdata | d1_cpu_rdata | d1_dma_rdata |
          {59'd0, d1_cpu_ack, d1_dma_ack, d1_cpu_stall, d1_mem_we, d1_mem_re}, 64'd0);
      chk("reset d3 outputs", d3_mem_addr | d3_mem_wdata | d3_cpu_rdata | d3_dma_rdata |
          {59'd0, d3_cpu_ack, d3_dma_ack, d3_cpu_stall, d3_mem_we, d3_mem_re}, 64'd0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
   endtask

   // Called at a negedge in an IDLE cycle; returns at the negedge after the ack.
   task automatic run_acc(input string tag, input bit sel, input bit dma, input bit we,
                          input logic [63:0] addr, input logic [63:0] wdata,
                          input logic [63:0] exp_rd, input int exp_lat);
      int  re0, we0, lat;
      bit  got, stall_bad, oack;
      re0 = sel ? re3 : re1;
      we0 = sel ? we3 : we1;
      got = 1'b0; stall_bad = 1'b0; oack = 1'b0; lat = -1;
      if (dma) begin
         dma_we = we; dma_addr = addr; dma_wdata = wdata; dma_req = 1'b1;
      end else begin
         cpu_we = we; cpu_addr = addr; cpu_wdata = wdata; cpu_req = 1'b1;
      end
      for (int c = 0; c < 20; c++) begin
         #1;
         if (f_ack(sel, dma)) begin
            got = 1'b1;
            lat = c;
            oack = f_ack(sel, !dma);
            break;
         end
         if (!dma && !(sel ? d3_cpu_stall : d1_cpu_stall)) stall_bad = 1'b1;
         @(negedge clk);
      end
      chk({tag, " ack seen"}, 64'(got), 64'd1);
      chk({tag, " latency"}, 64'(lat), 64'(exp_lat));
      chk({tag, " rdata"}, f_rd(sel, dma), exp_rd);
      chk({tag, " other ack"}, 64'(oack), 64'd0);
      chk({tag, " read cycles"}, 64'((sel ? re3 : re1) - re0), we ? 64'd0 : 64'(exp_lat - 1));
      chk({tag, " write cycles"}, 64'((sel ? we3 : we1) - we0), we ? 64'd1 : 64'd0);
      if (!dma) begin
         chk({tag, " stall before ack"}, 64'(stall_bad), 64'd0);
         chk({tag, " stall at ack"}, 64'(sel ? d3_cpu_stall : d1_cpu_stall), 64'd0);
      end
      cpu_req = 1'b0;
      dma_req = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      int          cpu_at, dma_at, ngr, last_at, bad_addr, ack_seen;
      logic [5:0]  order;
      logic [63:0] cpu_rd, dma_rd;
      logic [3:0]  exp_cnt [6];

      vecs[0] = '{"t1 cpu rd 10",   1'b0, 1'b0, 1'b0, 64'h10, 64'h0,    64'hDEAD, 2};
      vecs[1] = '{"dma wr 30",      1'b0, 1'b1, 1'b1, 64'h30, 64'hA5A5, 64'h0,    2};
      vecs[2] = '{"dma rd 30",      1'b0, 1'b1, 1'b0, 64'h30, 64'h0,    64'hA5A5, 2};
      vecs[3] = '{"cpu wr 40",      1'b0, 1'b0, 1'b1, 64'h40, 64'h1234, 64'hDEAD, 2};
      vecs[4] = '{"cpu rd 40",      1'b0, 1'b0, 1'b0, 64'h40, 64'h0,    64'h1234, 2};
      vecs[5] = '{"dma rd f8 ones", 1'b0, 1'b1, 1'b0, 64'hF8, 64'h0,    '1,       2};
      vecs[6] = '{"t4 dma wr 20",   1'b1, 1'b1, 1'b1, 64'h20, 64'h55,   64'h0,    4};
      vecs[7] = '{"t4 cpu rd 20",   1'b1, 1'b0, 1'b0, 64'h20, 64'h0,    64'h55,   4};
      vecs[8] = '{"lat3 dma rd 10", 1'b1, 1'b1, 1'b0, 64'h10, 64'h0,    64'hDEAD, 4};
      exp_cnt = '{4'd1, 4'd2, 4'd0, 4'd1, 4'd2, 4'd0};

      load(8'h10, 64'hDEAD);
      load(8'hF8, '1);
      load(8'h08, 64'h0808);
      load(8'h18, 64'h1818);
      load(8'h20, 64'h0);

      for (int i = 0; i < 9; i++) begin
         if (i == 0 || vecs[i].sel != vecs[i-1].sel) do_reset();
         run_acc(vecs[i].name, vecs[i].sel, vecs[i].dma, vecs[i].we, vecs[i].addr,
                 vecs[i].wdata, vecs[i].exp_rd, vecs[i].exp_lat);
      end

      // Simultaneous requests: CPU first, DMA in the following IDLE.
      do_reset();
      cpu_we = 1'b0; cpu_addr = 64'h10; cpu_req = 1'b1;
      dma_we = 1'b0; dma_addr = 64'h30; dma_req = 1'b1;
      cpu_at = -1; dma_at = -1; cpu_rd = '0; dma_rd = '0;
      for (int c = 0; c < 12; c++) begin
         #1;
         if (d1_cpu_ack) begin cpu_at = c; cpu_rd = d1_cpu_rdata; cpu_req = 1'b0; end
         if (d1_dma_ack) begin dma_at = c; dma_rd = d1_dma_rdata; dma_req = 1'b0; end
         @(negedge clk);
      end
      chk("t2 cpu ack cycle", 64'(cpu_at), 64'd2);
      chk("t2 dma ack cycle", 64'(dma_at), 64'd5);
      chk("t2 cpu rdata", cpu_rd, 64'hDEAD);
      chk("t2 dma rdata", dma_rd, 64'hA5A5);

      // Starvation guard with both requests held.
      do_reset();
      cpu_we = 1'b0; cpu_addr = 64'h10; cpu_req = 1'b1;
      dma_we = 1'b0; dma_addr = 64'h30; dma_req = 1'b1;
      ngr = 0; order = '0; last_at = -1;
      for (int c = 0; c < 40 && ngr < 6; c++) begin
         #1;
         if (d1_cpu_ack || d1_dma_ack) begin
            order[ngr] = d1_dma_ack;
            chk($sformatf("t3 starve_cnt grant %0d", ngr), 64'(d1.u_starve.cnt_q), 64'(exp_cnt[ngr]));
            ngr++;
            last_at = c;
         end
         @(negedge clk);
      end
      chk("t3 grant count", 64'(ngr), 64'd6);
      chk("t3 grant order", 64'(order), 64'b100100);
      chk("t3 sixth ack cycle", 64'(last_at), 64'd17);
      cpu_req = 1'b0; dma_req = 1'b0;
      @(negedge clk);
      @(negedge clk);

      // Reset during ACCESS aborts the CPU read.
      do_reset();
      cpu_we = 1'b0; cpu_addr = 64'h10; cpu_req = 1'b1;
      @(negedge clk);
      #1 chk("t5 in access", 64'(d1_mem_re), 64'd1);
      rst = 1'b0;
      #1;
      chk("t5 outputs cleared", d1_mem_addr | {62'd0, d1_mem_re, d1_cpu_ack}, 64'd0);
      chk("t5 stall follows req", 64'(d1_cpu_stall), 64'd1);
      cpu_req = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      ack_seen = 0;
      for (int c = 0; c < 4; c++) begin
         #1;
         if (d1_cpu_ack || d1_mem_re) ack_seen++;
         @(negedge clk);
      end
      chk("t5 no ack after abort", 64'(ack_seen), 64'd0);
      run_acc("t5 re-request", 1'b0, 1'b0, 1'b0, 64'h10, 64'h0, 64'hDEAD, 2);

      // Address changed after grant must not reach the memory.
      do_reset();
      cpu_we = 1'b0; cpu_addr = 64'h8; cpu_req = 1'b1;
      @(negedge clk);
      cpu_addr = 64'h18;
      bad_addr = 0;
      for (int c = 1; c < 4; c++) begin
         #1;
         if (d3_mem_addr !== 64'h8 || !d3_mem_re) bad_addr++;
         @(negedge clk);
      end
      #1;
      chk("t6 addr held", 64'(bad_addr), 64'd0);
      chk("t6 ack", 64'(d3_cpu_ack), 64'd1);
      chk("t6 rdata", d3_cpu_rdata, 64'h0808);
      cpu_req = 1'b0;
      @(negedge clk);

      chk("acks never together", 64'(both), 64'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single data memory between two requesters: the CPU MEM stage (requester 0) and a DMA/test-loader port (requester 1).
- Fixed priority goes to the CPU, with a starvation guard that forces a DMA grant after STARVE_MAX consecutive CPU grants while DMA waits.
- Each access is registered and multi-cycle, with a req/ack handshake per requester.
- Produces cpu_stall, which freezes the pipeline while a CPU memory access is outstanding.

Parameters:
- DATA_W, 64, data width of memory and ports.
- ADDR_W, 64, address width.
- MEM_LAT, 1, cycles mem_* is driven before mem_rdata is valid; legal range 1..15.
- STARVE_MAX, 4, maximum consecutive CPU grants while dma_req is high; legal range 1..15.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- cpu_req  in  1  CPU access request; held until cpu_ack.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  ADDR_W  CPU byte address.
- cpu_wdata  in  DATA_W  CPU write data.
- cpu_rdata  out  DATA_W  CPU read data; valid while cpu_ack = 1.
- cpu_ack  out  1  one-cycle completion pulse.
- cpu_stall  out  1  cpu_req & ~cpu_ack.
- dma_req  in  1  DMA access request; held until dma_ack.
- dma_we  in  1  1 = write.
- dma_addr  in  ADDR_W  DMA byte address.
- dma_wdata  in  DATA_W  DMA write data.
- dma_rdata  out  DATA_W  DMA read data; valid while dma_ack = 1.
- dma_ack  out  1  one-cycle completion pulse.
- mem_addr  out  ADDR_W  to datamem address.
- mem_we  out  1  to datamem write_enable.
- mem_re  out  1  to datamem read_enable.
- mem_wdata  out  DATA_W  to datamem write_data.
- mem_rdata  in  DATA_W  from datamem read_data.

Behaviour:
- Reset (rst = 0, asynchronous): state IDLE; owner CPU; starve_cnt 0; lat_cnt 0. All outputs 0 except cpu_stall, which follows cpu_req. Reset mid-access aborts the access with no ack.
- FSM states: IDLE, ACCESS, DONE.
- IDLE, arbitration:
  - If dma_req & (~cpu_req | starve_cnt == STARVE_MAX): grant DMA.
  - Else if cpu_req: grant CPU.
  - Else stay in IDLE.
  - On grant: latch the owner's we/addr/wdata into internal registers, lat_cnt <= MEM_LAT, go to ACCESS.
- ACCESS:
  - mem_addr and mem_wdata driven from the latched registers.
  - mem_re = ~latched_we in every ACCESS cycle.
  - mem_we = latched_we only in the first ACCESS cycle, so exactly one write occurs.
  - lat_cnt decrements each cycle. In the cycle where lat_cnt == 1, capture mem_rdata into the owner's rdata register and go to DONE.
- DONE: owner's ack = 1 for exactly one cycle; owner's rdata is held. Next state is IDLE.
- Outside ACCESS: mem_we = mem_re = 0; mem_addr and mem_wdata are 0.
- Latency: request sampled in IDLE at cycle t; ack at cycle t + MEM_LAT + 1. Next grant is earliest at t + MEM_LAT + 2, so back-to-back throughput is one access per MEM_LAT + 2 cycles.
- Requester inputs may change after grant; the latched values are used. A requester dropping req mid-access still receives its ack pulse. A req still high in the IDLE cycle after its ack is treated as a new request.
- Writes: ack is returned and rdata is left unchanged.
- Starvation counter, updated on each grant:
  - CPU granted while dma_req = 1: starve_cnt increments, saturating at STARVE_MAX.
  - DMA granted: starve_cnt clears.
  - CPU granted while dma_req = 0: starve_cnt clears.
- The non-owner's ack is always 0. cpu_ack and dma_ack are never high in the same cycle.
- cpu_rdata and dma_rdata hold their last captured value until the next read by that owner.

Decomposition:
- Package dmem_arb_pkg:
  - typedef enum arb_state_t {IDLE, ACCESS, DONE}.
  - typedef enum owner_t {OWN_CPU, OWN_DMA}.
  - localparam CNT_W = 4 for lat_cnt and starve_cnt.
- Sub-module starve_counter: saturating counter with inc, clr, sat outputs and asynchronous active-low reset. It is instantiated once for starve_cnt.
- The FSM, latches and output muxing live in dmem_arbiter.

Test Plan:
1. MEM_LAT = 1. CPU read 0x10 (memory holds 0xDEAD) with DMA idle. Expect: mem_re high for 1 cycle at t+1, cpu_ack at t+2, cpu_rdata = 0xDEAD, cpu_stall high for cycles t..t+1.
2. cpu_req and dma_req rise in the same cycle. Expect: CPU granted first (cpu_ack at t+2); DMA granted in the following IDLE, dma_ack at t+5.
3. STARVE_MAX = 2. cpu_req and dma_req held continuously. Expect grant order CPU, CPU, DMA, CPU, CPU, DMA; starve_cnt sequence 1, 2, 0.
4. MEM_LAT = 3. DMA writes 0x55 to 0x20, then CPU reads 0x20. Expect: mem_we high for exactly 1 cycle; dma_ack at t+4; cpu_rdata = 0x55.
5. rst asserted low during ACCESS of a CPU read. Expect: outputs 0 immediately, no cpu_ack, state IDLE after release. A CPU re-request then completes normally.
6. CPU changes cpu_addr from 0x8 to 0x18 one cycle after grant. Expect: mem_addr stays 0x8 for the whole access.
